// File: rtl/coin_credit_controller.sv
// Coin credit controller: detects new coins from the coin mux, accumulates credit,
// runs the vend sequence once the price is reached, then returns any change.
module coin_credit_controller #(
  parameter logic [7:0] PRICE       = 8'd65,
  parameter logic [7:0] MAX_CREDIT  = 8'd200,
  parameter int         VEND_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] coin_cents,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       vend,
  output logic       change_valid,
  output logic [7:0] change_cents,
  output logic       coin_reject,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [CW-1:0] VEND_LOAD = CW'(VEND_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_RETURN  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    prev_cents;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    credit_nxt;
  logic          reject_nxt;
  logic [8:0]    sum;
  logic          coin_event;
  logic          take_cancel;
  logic          over_max;
  logic          at_price;

  // A coin is a rising edge out of zero; nonzero-to-nonzero changes are ignored.
  assign coin_event  = (coin_cents != 8'd0) && (prev_cents == 8'd0);
  assign sum         = {1'b0, credit} + {1'b0, coin_cents};
  assign over_max    = sum > {1'b0, MAX_CREDIT};
  assign at_price    = sum >= {1'b0, PRICE};
  assign take_cancel = (state == S_COLLECT) && cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      prev_cents  <= 8'd0;
      cnt         <= '0;
      credit      <= 8'd0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_cents  <= coin_cents;
      cnt         <= cnt_nxt;
      credit      <= credit_nxt;
      coin_reject <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (take_cancel)
          state_nxt = S_RETURN;
        else if (coin_event && !over_max)
          state_nxt = at_price ? S_VEND : S_COLLECT;
      end
      S_VEND: begin
        if (cnt == '0)
          state_nxt = (credit != PRICE) ? S_RETURN : S_IDLE;
      end
      S_RETURN: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Credit, vend counter and reject strobe; cancel beats a same-cycle coin.
  always_comb begin
    credit_nxt = credit;
    cnt_nxt    = cnt;
    reject_nxt = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (take_cancel) begin
          reject_nxt = coin_event;
        end else if (coin_event) begin
          if (over_max) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = sum[7:0];
            if (at_price) cnt_nxt = VEND_LOAD;
          end
        end
      end
      S_VEND: begin
        reject_nxt = coin_event;
        if (cnt == '0) credit_nxt = credit - PRICE;
        else           cnt_nxt    = cnt - CW'(1);
      end
      S_RETURN: begin
        reject_nxt = coin_event;
        credit_nxt = 8'd0;
      end
      default: credit_nxt = 8'd0;
    endcase
  end

  always_comb begin
    vend         = (state == S_VEND);
    busy         = (state == S_VEND) || (state == S_RETURN);
    change_valid = (state == S_RETURN);
    change_cents = (state == S_RETURN) ? credit : 8'd0;
    state_dbg    = state;
  end

endmodule

// File: tb/tb_coin_credit_controller.sv
// Directed bench for coin_credit_controller: default instance plus a low-ceiling
// instance (MAX_CREDIT = 30) sharing clock, reset and cancel.
module tb_coin_credit_controller;

  logic       clk;
  logic       reset;
  logic [7:0] coin_cents;
  logic       cancel;
  logic [7:0] credit;
  logic       vend;
  logic       change_valid;
  logic [7:0] change_cents;
  logic       coin_reject;
  logic       busy;
  logic [1:0] state_dbg;

  logic [7:0] coin2;
  logic [7:0] credit2;
  logic       vend2;
  logic       change_valid2;
  logic [7:0] change_cents2;
  logic       coin_reject2;
  logic       busy2;
  logic [1:0] state_dbg2;

  int checks = 0;
  int errors = 0;

  coin_credit_controller dut (
    .clk(clk), .reset(reset), .coin_cents(coin_cents), .cancel(cancel),
    .credit(credit), .vend(vend), .change_valid(change_valid),
    .change_cents(change_cents), .coin_reject(coin_reject), .busy(busy),
    .state_dbg(state_dbg)
  );

  coin_credit_controller #(.PRICE(8'd65), .MAX_CREDIT(8'd30), .VEND_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .coin_cents(coin2), .cancel(cancel),
    .credit(credit2), .vend(vend2), .change_valid(change_valid2),
    .change_cents(change_cents2), .coin_reject(coin_reject2), .busy(busy2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a coin for one edge, then drops the input back to zero.
  task automatic insert(input logic [7:0] v);
    coin_cents = v;
    tick();
    coin_cents = 8'd0;
  endtask

  // Counts vend/change cycles from now until the sequence has settled.
  task automatic run_vend(output int vc, output int cc, output logic [7:0] cents);
    vc = 0; cc = 0; cents = 8'd0;
    for (int i = 0; i < 12; i++) begin
      if (vend) vc++;
      if (change_valid) begin cc++; cents = change_cents; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coin_cents = 8'd25; cancel = 1'b0; coin2 = 8'd0;
    tick(); tick();
    checks++;
    if ({credit, vend, change_valid, change_cents, coin_reject, busy, state_dbg} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got credit=%0d vend=%0d cv=%0d cc=%0d rej=%0d busy=%0d st=%0d exp all 0",
               credit, vend, change_valid, change_cents, coin_reject, busy, state_dbg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (credit !== 8'd25) begin errors++; $display("FAIL first_coin_after_reset got %0d exp 25", credit); end
    tick(); tick(); tick();
    checks++;
    if (credit !== 8'd25) begin errors++; $display("FAIL held_coin_once got %0d exp 25", credit); end
    coin_cents = 8'd0; tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++;
    if ({change_valid, change_cents} !== {1'b1, 8'd25}) begin
      errors++; $display("FAIL reset_refund got cv=%0d cents=%0d exp cv=1 cents=25", change_valid, change_cents);
    end
    tick();
    checks++;
    if ({credit, state_dbg} !== 10'd0) begin
      errors++; $display("FAIL reset_refund_clear got credit=%0d st=%0d exp 0 0", credit, state_dbg);
    end
  endtask

  task automatic test_exact_price();
    int vc, cc;
    logic [7:0] cents;
    insert(8'd25);
    checks++; if (credit !== 8'd25) begin errors++; $display("FAIL exact_c1 got %0d exp 25", credit); end
    tick(); insert(8'd25);
    checks++; if (credit !== 8'd50) begin errors++; $display("FAIL exact_c2 got %0d exp 50", credit); end
    tick(); insert(8'd10);
    checks++; if (credit !== 8'd60) begin errors++; $display("FAIL exact_c3 got %0d exp 60", credit); end
    tick(); insert(8'd5);
    checks++; if (credit !== 8'd65) begin errors++; $display("FAIL exact_c4 got %0d exp 65", credit); end
    run_vend(vc, cc, cents);
    checks++; if (vc !== 4) begin errors++; $display("FAIL exact_vend_cycles got %0d exp 4", vc); end
    checks++; if (cc !== 0) begin errors++; $display("FAIL exact_no_change got %0d exp 0", cc); end
    checks++;
    if ({credit, state_dbg} !== 10'd0) begin
      errors++; $display("FAIL exact_idle got credit=%0d st=%0d exp 0 0", credit, state_dbg);
    end
  endtask

  task automatic test_change();
    int vc, cc;
    logic [7:0] cents;
    insert(8'd25); tick(); insert(8'd25); tick(); insert(8'd25);
    checks++; if (credit !== 8'd75) begin errors++; $display("FAIL change_credit got %0d exp 75", credit); end
    run_vend(vc, cc, cents);
    checks++; if (vc !== 4) begin errors++; $display("FAIL change_vend_cycles got %0d exp 4", vc); end
    checks++;
    if (cc !== 1 || cents !== 8'd10) begin
      errors++; $display("FAIL change_return got strobes=%0d cents=%0d exp 1 10", cc, cents);
    end
    checks++;
    if ({credit, state_dbg} !== 10'd0) begin
      errors++; $display("FAIL change_idle got credit=%0d st=%0d exp 0 0", credit, state_dbg);
    end
  endtask

  task automatic test_cancel();
    insert(8'd10); tick(); insert(8'd5);
    checks++; if (credit !== 8'd15) begin errors++; $display("FAIL cancel_credit got %0d exp 15", credit); end
    tick();
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++;
    if ({change_valid, change_cents, vend} !== {1'b1, 8'd15, 1'b0}) begin
      errors++; $display("FAIL cancel_refund got cv=%0d cents=%0d vend=%0d exp 1 15 0", change_valid, change_cents, vend);
    end
    tick();
    checks++;
    if ({credit, change_valid} !== 9'd0) begin
      errors++; $display("FAIL cancel_clear got credit=%0d cv=%0d exp 0 0", credit, change_valid);
    end
    cancel = 1'b1; tick(); tick(); cancel = 1'b0;
    checks++;
    if ({change_valid, state_dbg, credit, busy} !== 12'd0) begin
      errors++; $display("FAIL cancel_idle_ignored got cv=%0d st=%0d credit=%0d busy=%0d exp 0", change_valid, state_dbg, credit, busy);
    end
    // cancel and coin on the same edge: cancel wins, coin refused
    insert(8'd10); tick();
    coin_cents = 8'd5; cancel = 1'b1; tick(); coin_cents = 8'd0; cancel = 1'b0;
    checks++;
    if ({change_valid, change_cents, coin_reject} !== {1'b1, 8'd10, 1'b1}) begin
      errors++; $display("FAIL cancel_beats_coin got cv=%0d cents=%0d rej=%0d exp 1 10 1", change_valid, change_cents, coin_reject);
    end
    tick();
  endtask

  task automatic test_edge_detect();
    coin_cents = 8'd10; tick();
    coin_cents = 8'd5;  tick();
    checks++; if (credit !== 8'd10) begin errors++; $display("FAIL nonzero_to_nonzero got %0d exp 10", credit); end
    coin_cents = 8'd0; tick();
    insert(8'd5);
    checks++; if (credit !== 8'd15) begin errors++; $display("FAIL coin_after_gap got %0d exp 15", credit); end
    tick();
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
    insert(8'd255);
    checks++;
    if ({coin_reject, credit, state_dbg} !== 11'b1_00000000_00) begin
      errors++; $display("FAIL over_max_reject got rej=%0d credit=%0d st=%0d exp 1 0 0", coin_reject, credit, state_dbg);
    end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_one_cycle got %0d exp 0", coin_reject); end
  endtask

  task automatic test_reject_in_vend();
    insert(8'd25); tick(); insert(8'd25); tick(); insert(8'd25);
    tick();
    coin_cents = 8'd10; tick(); coin_cents = 8'd0;
    checks++;
    if ({coin_reject, credit, vend} !== {1'b1, 8'd75, 1'b1}) begin
      errors++; $display("FAIL vend_coin_reject got rej=%0d credit=%0d vend=%0d exp 1 75 1", coin_reject, credit, vend);
    end
    tick();
    checks++;
    if ({coin_reject, vend} !== 2'b01) begin
      errors++; $display("FAIL vend_reject_pulse got rej=%0d vend=%0d exp 0 1", coin_reject, vend);
    end
    tick();
    checks++;
    if ({change_valid, change_cents, vend, busy} !== {1'b1, 8'd10, 1'b0, 1'b1}) begin
      errors++; $display("FAIL vend_reject_change got cv=%0d cents=%0d vend=%0d busy=%0d exp 1 10 0 1", change_valid, change_cents, vend, busy);
    end
    tick();
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL vend_reject_clear got %0d exp 0", credit); end
  endtask

  task automatic test_max_credit();
    coin2 = 8'd25; tick(); coin2 = 8'd0;
    checks++; if (credit2 !== 8'd25) begin errors++; $display("FAIL max_c1 got %0d exp 25", credit2); end
    tick();
    coin2 = 8'd10; tick(); coin2 = 8'd0;
    checks++;
    if ({coin_reject2, credit2} !== {1'b1, 8'd25}) begin
      errors++; $display("FAIL max_reject got rej=%0d credit=%0d exp 1 25", coin_reject2, credit2);
    end
    tick();
    checks++;
    if ({coin_reject2, credit2} !== {1'b0, 8'd25}) begin
      errors++; $display("FAIL max_after got rej=%0d credit=%0d exp 0 25", coin_reject2, credit2);
    end
  endtask

  task automatic test_reset_mid_vend();
    int vc = 0;
    int cc = 0;
    insert(8'd25); tick(); insert(8'd25); tick(); insert(8'd25);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({vend, change_valid, credit, busy} !== 11'd0) begin
      errors++; $display("FAIL reset_abort got vend=%0d cv=%0d credit=%0d busy=%0d exp 0", vend, change_valid, credit, busy);
    end
    for (int i = 0; i < 8; i++) begin
      if (vend) vc++;
      if (change_valid) cc++;
      tick();
    end
    checks++;
    if (vc !== 0 || cc !== 0 || credit !== 8'd0) begin
      errors++; $display("FAIL reset_abort_after got vend=%0d cv=%0d credit=%0d exp 0 0 0", vc, cc, credit);
    end
  endtask

  initial begin
    reset = 1'b1; coin_cents = 8'd0; cancel = 1'b0; coin2 = 8'd0;
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_edge_detect();
    test_reject_in_vend();
    test_max_credit();
    test_reset_mid_vend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
